// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and FSM state type shared by the multi-cycle ALU.
package alu_pkg;

    // Primary opcodes (func)
    localparam logic [3:0] FUNC_ADD  = 4'b0000;
    localparam logic [3:0] FUNC_SUB  = 4'b0001;
    localparam logic [3:0] FUNC_SLL  = 4'b0011;
    localparam logic [3:0] FUNC_SRL  = 4'b0100;
    localparam logic [3:0] FUNC_SPEC = 4'b0111;
    localparam logic [3:0] FUNC_BLT  = 4'b1010;
    localparam logic [3:0] FUNC_BE   = 4'b1011;

    // Sub-opcodes (spec_fun), only meaningful when func == FUNC_SPEC
    localparam logic [2:0] SPEC_INC  = 3'b000;
    localparam logic [2:0] SPEC_AND1 = 3'b001;
    localparam logic [2:0] SPEC_DEC  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: iterative logical shifter, one bit position per cycle.
// The first shift is applied as the operand is loaded, so a shift by N
// finishes N cycles after load and the owner can latch data_o the cycle
// done_o is seen.
module alu_shifter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic             dir_i,     // 0 = left, 1 = right
    input  logic [CNT_W-1:0] amount_i,  // 1 .. WIDTH-1
    input  logic [WIDTH-1:0] data_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             act_q, act_d;

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v, input logic right);
        return right ? (v >> 1) : (v << 1);
    endfunction

    // Next-state: load applies the first shift, then one shift per cycle until the count drains
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        act_d  = act_q;
        if (load_i) begin
            data_d = step(data_i, dir_i);
            cnt_d  = amount_i - CNT_W'(1);
            dir_d  = dir_i;
            act_d  = 1'b1;
        end else if (act_q) begin
            if (cnt_q != '0) begin
                data_d = step(data_q, dir_q);
                cnt_d  = cnt_q - CNT_W'(1);
            end else begin
                // done_o is high for exactly this one cycle
                act_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            data_q <= '0;
            cnt_q  <= '0;
            dir_q  <= 1'b0;
            act_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            act_q  <= act_d;
        end
    end

    assign busy_o = act_q && (cnt_q != '0);
    assign done_o = act_q && (cnt_q == '0);
    assign data_o = data_q;

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes on request and result.
// Single-cycle ops are computed at acceptance and registered; shifts by
// 1..WIDTH-1 iterate in alu_shifter. All outputs come straight from flops.
// Build option: define ALU_MC_SUB_EN to enable func 0001 (reg1 - reg2).
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] reg1,
    input  logic [WIDTH-1:0] reg2,
    input  logic [3:0]       func,
    input  logic [2:0]       spec_fun,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             br_out,
    output logic             err
);

    localparam logic [WIDTH-1:0] W_LIM = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    state_e           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic             err_q, err_d;

    logic             accept;
    logic [WIDTH-1:0] op_res;
    logic             op_br, op_err, op_iter, op_dir;

    logic             shf_load, shf_busy, shf_done;
    logic [WIDTH-1:0] shf_data;

    assign accept = in_valid && in_ready_q;

    // Decode request: single-cycle result, or flag that the shifter must iterate
    always_comb begin
        op_res  = '0;
        op_br   = 1'b0;
        op_err  = 1'b0;
        op_iter = 1'b0;
        op_dir  = 1'b0;
        case (func)
            FUNC_ADD: op_res = reg1 + reg2;
`ifdef ALU_MC_SUB_EN
            FUNC_SUB: op_res = reg1 - reg2;
`endif
            FUNC_SLL, FUNC_SRL: begin
                op_dir = (func == FUNC_SRL);
                // Degenerate amounts resolve immediately without the shifter
                if (reg2 == '0)         op_res  = reg1;
                else if (reg2 >= W_LIM) op_res  = '0;
                else                    op_iter = 1'b1;
            end
            FUNC_BLT: op_br = (reg1 < reg2);
            FUNC_BE:  op_br = (reg1 == reg2);
            FUNC_SPEC: begin
                case (spec_fun)
                    SPEC_INC:  op_res = reg1 + ONE;
                    SPEC_AND1: op_res = reg1 & ONE;
                    SPEC_DEC:  op_res = reg1 - ONE;
                    default:   op_err = 1'b1;
                endcase
            end
            default: op_err = 1'b1;
        endcase
    end

    // FSM next-state, shifter launch and output register next values
    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        br_d     = br_q;
        err_d    = err_q;
        shf_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (op_iter) begin
                        state_d  = ST_SHIFT;
                        shf_load = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                        res_d   = op_res;
                        br_d    = op_br;
                        err_d   = op_err;
                    end
                end
            end
            ST_SHIFT: begin
                if (shf_done) begin
                    state_d = ST_HOLD;
                    res_d   = shf_data;
                    br_d    = 1'b0;
                    err_d   = 1'b0;
                end else if (!shf_busy) begin
                    // Shifter idle without finishing: drop the op rather than hang
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_HOLD);
    end

    // State and output registers; reset wins over any handshake
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            br_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            br_q        <= br_d;
            err_q       <= err_d;
        end
    end

    alu_shifter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_shifter (
        .clock    (clock),
        .reset    (reset),
        .load_i   (shf_load),
        .dir_i    (op_dir),
        .amount_i (reg2[CNT_W-1:0]),
        .data_i   (reg1),
        .busy_o   (shf_busy),
        .done_o   (shf_done),
        .data_o   (shf_data)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign br_out    = br_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed and randomized checks of alu_mc against an
// arithmetic reference model of the opcode table and latency rules.
module tb_alu_mc;
    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] reg1, reg2;
    logic [3:0]   func;
    logic [2:0]   spec_fun;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic         br_out;
    logic         err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .reg1      (reg1),
        .reg2      (reg2),
        .func      (func),
        .spec_fun  (spec_fun),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .br_out    (br_out),
        .err       (err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference: result, branch, error and latency straight from the opcode table
    function automatic void model(input logic [3:0] f, input logic [2:0] sf,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic br,
                                  output logic e, output int lat);
        r = '0; br = 1'b0; e = 1'b0; lat = 1;
        case (f)
            4'd0: r = a + b;
`ifdef ALU_MC_SUB_EN
            4'd1: r = a - b;
`endif
            4'd3: if (int'(b) < W) begin r = a << b; lat = (b == 0) ? 1 : int'(b) + 1; end
            4'd4: if (int'(b) < W) begin r = a >> b; lat = (b == 0) ? 1 : int'(b) + 1; end
            4'd10: br = (a < b);
            4'd11: br = (a == b);
            4'd7: case (sf)
                3'd0: r = a + W'(1);
                3'd1: r = a & W'(1);
                3'd3: r = a - W'(1);
                default: e = 1'b1;
            endcase
            default: e = 1'b1;
        endcase
    endfunction

    // Present one request; returns #1 after the accepting edge
    task automatic issue(input logic [3:0] f, input logic [2:0] sf,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        int guard = 0;
        while (in_ready !== 1'b1 && guard < 50) begin @(posedge clock); #1; guard++; end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL issue_ready got=%b want=1", in_ready); end
        func = f; spec_fun = sf; reg1 = a; reg2 = b; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    // Count edges from acceptance (inclusive) until out_valid is seen
    task automatic wait_result(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin @(posedge clock); #1; lat++; end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        func = '0; spec_fun = '0; reg1 = '0; reg2 = '0;
        repeat (3) @(posedge clock);
        #1;
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (res !== 8'h00)      begin bad++; $display("FAIL rst_res got=%h want=00", res); end
        total++; if (br_out !== 1'b0)    begin bad++; $display("FAIL rst_br got=%b want=0", br_out); end
        total++; if (err !== 1'b0)       begin bad++; $display("FAIL rst_err got=%b want=0", err); end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_add();
        int lat;
        out_ready = 1'b1;
        issue(4'b0000, 3'd0, 8'hFF, 8'h02);
        wait_result(lat);
        total++; if (lat != 1)       begin bad++; $display("FAIL add_lat got=%0d want=1", lat); end
        total++; if (res !== 8'h01)  begin bad++; $display("FAIL add_res got=%h want=01", res); end
        total++; if (br_out !== 1'b0) begin bad++; $display("FAIL add_br got=%b want=0", br_out); end
        total++; if (err !== 1'b0)   begin bad++; $display("FAIL add_err got=%b want=0", err); end
        @(posedge clock); #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin bad++; $display("FAIL add_return got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid); end
    endtask

    task automatic test_shift();
        logic [3:0]   tf [6] = '{4'b0011, 4'b0100, 4'b0011, 4'b0100, 4'b0011, 4'b0100};
        logic [W-1:0] ta [6] = '{8'h81, 8'hC3, 8'h5A, 8'h80, 8'h01, 8'hF0};
        logic [W-1:0] tb [6] = '{8'd3, 8'd9, 8'd0, 8'd7, 8'd1, 8'd8};
        logic [W-1:0] tr [6] = '{8'h08, 8'h00, 8'h5A, 8'h01, 8'h02, 8'h00};
        int           tl [6] = '{4, 1, 1, 8, 2, 1};
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            issue(tf[i], 3'd0, ta[i], tb[i]);
            wait_result(lat);
            total++; if (lat != tl[i])  begin bad++; $display("FAIL shift%0d_lat got=%0d want=%0d", i, lat, tl[i]); end
            total++; if (res !== tr[i]) begin bad++; $display("FAIL shift%0d_res got=%h want=%h", i, res, tr[i]); end
            total++; if (br_out !== 1'b0 || err !== 1'b0)
                begin bad++; $display("FAIL shift%0d_flags got br=%b err=%b want 0 0", i, br_out, err); end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_branch();
        logic [3:0]   tf [4] = '{4'b1010, 4'b1011, 4'b1010, 4'b1011};
        logic [W-1:0] ta [4] = '{8'd3, 8'h7A, 8'd5, 8'h01};
        logic [W-1:0] tb [4] = '{8'd5, 8'h7A, 8'd3, 8'h02};
        logic         tbr[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(tf[i], 3'd0, ta[i], tb[i]);
            wait_result(lat);
            total++; if (lat != 1)          begin bad++; $display("FAIL br%0d_lat got=%0d want=1", i, lat); end
            total++; if (br_out !== tbr[i]) begin bad++; $display("FAIL br%0d_flag got=%b want=%b", i, br_out, tbr[i]); end
            total++; if (res !== 8'h00)     begin bad++; $display("FAIL br%0d_res got=%h want=00", i, res); end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_spec_hold();
        int lat;
        out_ready = 1'b0;
        issue(4'b0111, 3'b000, 8'hFF, 8'h00);
        wait_result(lat);
        total++; if (lat != 1) begin bad++; $display("FAIL hold_lat got=%0d want=1", lat); end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (res !== 8'h00 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL hold_c%0d got res=%h rdy=%b vld=%b want res=00 rdy=0 vld=1", i, res, in_ready, out_valid);
            end
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin bad++; $display("FAIL hold_release got rdy=%b vld=%b want 1 0", in_ready, out_valid); end
    endtask

    task automatic test_err();
        int lat;
        out_ready = 1'b1;
        issue(4'b0001, 3'd0, 8'd2, 8'd5);
        wait_result(lat);
`ifdef ALU_MC_SUB_EN
        total++; if (res !== 8'hFD || err !== 1'b0)
            begin bad++; $display("FAIL sub got res=%h err=%b want FD 0", res, err); end
`else
        total++; if (res !== 8'h00 || err !== 1'b1)
            begin bad++; $display("FAIL sub_unsup got res=%h err=%b want 00 1", res, err); end
`endif
        @(posedge clock); #1;
        issue(4'b1111, 3'd0, 8'h33, 8'h44);
        wait_result(lat);
        total++; if (res !== 8'h00 || err !== 1'b1 || br_out !== 1'b0)
            begin bad++; $display("FAIL bad_func got res=%h err=%b br=%b want 00 1 0", res, err, br_out); end
        @(posedge clock); #1;
        issue(4'b0111, 3'b010, 8'h33, 8'h44);
        wait_result(lat);
        total++; if (res !== 8'h00 || err !== 1'b1)
            begin bad++; $display("FAIL bad_spec got res=%h err=%b want 00 1", res, err); end
        @(posedge clock); #1;
    endtask

    task automatic test_reset_mid_shift();
        int lat;
        bit seen = 1'b0;
        out_ready = 1'b1;
        issue(4'b0011, 3'd0, 8'h81, 8'd6);
        @(posedge clock); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_busy got vld=%b want 0", out_valid); end
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || res !== 8'h00)
            begin bad++; $display("FAIL mid_rst got rdy=%b vld=%b res=%h want 1 0 00", in_ready, out_valid, res); end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        total++; if (seen) begin bad++; $display("FAIL mid_ghost got result after reset want none"); end
        issue(4'b0000, 3'd0, 8'd1, 8'd1);
        wait_result(lat);
        total++; if (lat != 1 || res !== 8'h02)
            begin bad++; $display("FAIL mid_after got lat=%0d res=%h want 1 02", lat, res); end
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back();
        int lat, t0, t1;
        logic [W-1:0] a, b;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = W'($urandom); b = W'($urandom);
            issue(4'b0000, 3'd0, a, b);
            t0 = cyc;
            wait_result(lat);
            total++; if (res !== W'(a + b) || in_ready !== 1'b0)
                begin bad++; $display("FAIL b2b%0d_res got res=%h rdy=%b want %h 0", i, res, in_ready, W'(a + b)); end
            issue(4'b0111, 3'b011, a, b);
            t1 = cyc;
            total++; if (t1 - t0 != 2)
                begin bad++; $display("FAIL b2b%0d_interval got=%0d want=2", i, t1 - t0); end
            wait_result(lat);
            total++; if (res !== W'(a - 1))
                begin bad++; $display("FAIL b2b%0d_dec got=%h want=%h", i, res, W'(a - 1)); end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_random();
        logic [3:0]   f;
        logic [2:0]   sf;
        logic [W-1:0] a, b, er;
        logic         ebr, ee;
        int           elat, lat, hold;
        for (int i = 0; i < 40; i++) begin
            f  = 4'($urandom_range(0, 15));
            sf = 3'($urandom_range(0, 7));
            a  = W'($urandom);
            b  = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, W + 3)) : W'($urandom);
            model(f, sf, a, b, er, ebr, ee, elat);
            hold = $urandom_range(0, 3);
            out_ready = (hold == 0);
            issue(f, sf, a, b);
            wait_result(lat);
            total++;
            if (lat != elat || res !== er || br_out !== ebr || err !== ee) begin
                bad++;
                $display("FAIL rnd%0d f=%b sf=%b a=%h b=%h got lat=%0d res=%h br=%b err=%b want lat=%0d res=%h br=%b err=%b",
                         i, f, sf, a, b, lat, res, br_out, err, elat, er, ebr, ee);
            end
            for (int h = 0; h < hold; h++) begin
                @(posedge clock); #1;
                total++;
                if (out_valid !== 1'b1 || res !== er || br_out !== ebr || err !== ee) begin
                    bad++;
                    $display("FAIL rnd%0d_stable vld=%b res=%h br=%b err=%b want 1 %h %b %b", i, out_valid, res, br_out, err, er, ebr, ee);
                end
            end
            out_ready = 1'b1;
            @(posedge clock); #1;
            total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
                begin bad++; $display("FAIL rnd%0d_done got vld=%b rdy=%b want 0 1", i, out_valid, in_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_shift();
        test_branch();
        test_spec_hold();
        test_err();
        test_reset_mid_shift();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
